bubble_param_ctrl: RTL and testbench

BUBBLE_PARAM_CTRL -- requirements
Module: bubble_param_ctrl

---
 rtl/bubble_param_ctrl_pkg.sv | 56 +++++
 rtl/bubble_param_ctrl_if.sv | 21 ++
 rtl/bubble_param_ctrl_key_repeat.sv | 83 ++++++++
 rtl/bubble_param_ctrl.sv | 132 +++++++++++++
 tb/tb_bubble_param_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/bubble_param_ctrl_pkg.sv
// Shared constants, repeat-state type and key priority helper for the
// bubble animation parameter controller.
package bubble_pkg;

    // Joystick word bit positions
    localparam int BTN_IN     = 4;
    localparam int BTN_OUT    = 5;
    localparam int BTN_FASTER = 6;
    localparam int BTN_SLOWER = 7;
    localparam int BTN_PAUSE  = 8;
    localparam int BTN_TRAILS = 9;

    // Positions inside the registered button slice joystick_0[9:4]
    localparam int KEY_IN     = BTN_IN     - BTN_IN;
    localparam int KEY_OUT    = BTN_OUT    - BTN_IN;
    localparam int KEY_FASTER = BTN_FASTER - BTN_IN;
    localparam int KEY_SLOWER = BTN_SLOWER - BTN_IN;
    localparam int KEY_PAUSE  = BTN_PAUSE  - BTN_IN;
    localparam int KEY_TRAILS = BTN_TRAILS - BTN_IN;

    // Defaults and saturation limits
    localparam logic [3:0] ZOOM_DEFAULT  = 4'd8;
    localparam logic [2:0] SPEED_DEFAULT = 3'd3;
    localparam logic [3:0] ZOOM_MAX      = 4'd15;
    localparam logic [2:0] SPEED_MAX     = 3'd7;

    // Auto-repeat timing in frame ticks
    localparam logic [4:0] REPEAT_DELAY = 5'd24;
    localparam logic [4:0] REPEAT_RATE  = 5'd6;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_FIRST  = 2'd1,
        RPT_DELAY  = 2'd2,
        RPT_REPEAT = 2'd3
    } rpt_state_t;

    // One-hot of the highest-priority held key: In > Out > Faster > Slower
    function automatic logic [3:0] prio_onehot(input logic [3:0] held);
        logic [3:0] sel;
        sel = 4'b0000;
        if (held[KEY_IN]) begin
            sel = 4'b0001;
        end else if (held[KEY_OUT]) begin
            sel = 4'b0010;
        end else if (held[KEY_FASTER]) begin
            sel = 4'b0100;
        end else if (held[KEY_SLOWER]) begin
            sel = 4'b1000;
        end else begin
            sel = 4'b0000;
        end
        return sel;
    endfunction

endpackage

// File: rtl/bubble_param_ctrl_if.sv
// Joystick/vblank inputs and renderer parameter outputs of the controller.
interface bubble_param_ctrl_if;
    logic [31:0] joystick_0;
    logic        vblank;
    logic [3:0]  zoom;
    logic [2:0]  speed;
    logic        paused;
    logic        trails;
    logic        advance;
    logic [3:0]  step;

    modport master (
        output joystick_0, vblank,
        input  zoom, speed, paused, trails, advance, step
    );

    modport slave (
        input  joystick_0, vblank,
        output zoom, speed, paused, trails, advance, step
    );
endinterface

// File: rtl/bubble_param_ctrl_key_repeat.sv
// Auto-repeat engine shared by In/Out/Faster/Slower: picks the highest
// priority held key and emits a one-cycle action pulse on the frame ticks
// where that key should take effect (first tick, after 24, then every 6).
module bubble_key_repeat
    import bubble_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [3:0] held,
    output logic [3:0] act
);

    logic [3:0]  sel_s;
    rpt_state_t  state_r;
    logic [3:0]  key_r;
    logic [4:0]  cnt_r;
    logic        fire_s;

    assign sel_s = prio_onehot(held);

    // Decide whether this tick applies the active key's action
    always_comb begin
        fire_s = 1'b0;
        if (tick && (sel_s == key_r)) begin
            case (state_r)
                RPT_FIRST:  fire_s = 1'b1;
                RPT_DELAY:  fire_s = (cnt_r == (REPEAT_DELAY - 5'd1));
                RPT_REPEAT: fire_s = (cnt_r == (REPEAT_RATE - 5'd1));
                default:    fire_s = 1'b0;
            endcase
        end else begin
            fire_s = 1'b0;
        end
    end

    assign act = fire_s ? key_r : 4'b0000;

    // Repeat state machine and frame-tick counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RPT_IDLE;
            key_r   <= 4'b0000;
            cnt_r   <= 5'd0;
        end else if (sel_s != key_r) begin
            // Release or a change of active key restarts the engine
            key_r   <= sel_s;
            cnt_r   <= 5'd0;
            state_r <= (sel_s != 4'b0000) ? RPT_FIRST : RPT_IDLE;
        end else if (tick) begin
            case (state_r)
                RPT_IDLE: begin
                    state_r <= RPT_IDLE;
                    cnt_r   <= 5'd0;
                end
                RPT_FIRST: begin
                    state_r <= RPT_DELAY;
                    cnt_r   <= 5'd0;
                end
                RPT_DELAY: begin
                    if (cnt_r == (REPEAT_DELAY - 5'd1)) begin
                        state_r <= RPT_REPEAT;
                        cnt_r   <= 5'd0;
                    end else begin
                        cnt_r   <= cnt_r + 5'd1;
                    end
                end
                RPT_REPEAT: begin
                    if (cnt_r == (REPEAT_RATE - 5'd1)) begin
                        cnt_r <= 5'd0;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                default: begin
                    state_r <= RPT_IDLE;
                    cnt_r   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bubble_param_ctrl.sv
// Turns joystick buttons into zoom/speed/pause/trails parameters for the
// bubble renderer, updating them once per frame (vblank rising edge) and
// pulsing advance/step to move animation time forward.
module bubble_param_ctrl (
    input  logic               clk,
    input  logic               reset_n,
    bubble_param_ctrl_if.slave bus
);
    import bubble_pkg::*;

    logic [5:0] joy_r;
    logic [1:0] tog_prev_r;
    logic       vblank_r;
    logic       vblank_prev_r;
    logic [3:0] zoom_r;
    logic [2:0] speed_r;
    logic       paused_r;
    logic       trails_r;
    logic       pend_pause_r;
    logic       pend_trails_r;
    logic       advance_r;
    logic [3:0] step_r;

    logic       tick_s;
    logic       tick_next_s;
    logic [1:0] press_s;
    logic [3:0] act_s;
    logic [3:0] zoom_next_s;
    logic [2:0] speed_next_s;
    logic       paused_next_s;
    logic       trails_next_s;
    logic       pend_pause_next_s;
    logic       pend_trails_next_s;
    logic       unused_joy_s;

    assign unused_joy_s = ^{bus.joystick_0[31:BTN_TRAILS+1], bus.joystick_0[BTN_IN-1:0]};

    assign tick_s      = vblank_r & ~vblank_prev_r;
    // Predicts tick_s of the next cycle so advance can be a register
    assign tick_next_s = bus.vblank & ~vblank_r;
    assign press_s     = joy_r[KEY_TRAILS:KEY_PAUSE] & ~tog_prev_r;

    bubble_key_repeat u_key_repeat (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick_s),
        .held    (joy_r[KEY_SLOWER:KEY_IN]),
        .act     (act_s)
    );

    // Next parameter values: everything moves only on a frame tick
    always_comb begin
        zoom_next_s        = zoom_r;
        speed_next_s       = speed_r;
        paused_next_s      = paused_r;
        trails_next_s      = trails_r;
        pend_pause_next_s  = pend_pause_r  | press_s[0];
        pend_trails_next_s = pend_trails_r | press_s[1];
        if (tick_s) begin
            pend_pause_next_s  = 1'b0;
            pend_trails_next_s = 1'b0;
            if (pend_pause_r | press_s[0]) begin
                paused_next_s = ~paused_r;
            end else begin
                paused_next_s = paused_r;
            end
            if (pend_trails_r | press_s[1]) begin
                trails_next_s = ~trails_r;
            end else begin
                trails_next_s = trails_r;
            end
            if (act_s[KEY_IN] && (zoom_r != ZOOM_MAX)) begin
                zoom_next_s = zoom_r + 4'd1;
            end else if (act_s[KEY_OUT] && (zoom_r != 4'd0)) begin
                zoom_next_s = zoom_r - 4'd1;
            end else begin
                zoom_next_s = zoom_r;
            end
            if (act_s[KEY_FASTER] && (speed_r != SPEED_MAX)) begin
                speed_next_s = speed_r + 3'd1;
            end else if (act_s[KEY_SLOWER] && (speed_r != 3'd0)) begin
                speed_next_s = speed_r - 3'd1;
            end else begin
                speed_next_s = speed_r;
            end
        end else begin
            zoom_next_s   = zoom_r;
            speed_next_s  = speed_r;
            paused_next_s = paused_r;
            trails_next_s = trails_r;
        end
    end

    // Input history, parameter registers and the advance/step outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joy_r         <= 6'd0;
            tog_prev_r    <= 2'd0;
            vblank_r      <= 1'b0;
            vblank_prev_r <= 1'b0;
            zoom_r        <= ZOOM_DEFAULT;
            speed_r       <= SPEED_DEFAULT;
            paused_r      <= 1'b0;
            trails_r      <= 1'b0;
            pend_pause_r  <= 1'b0;
            pend_trails_r <= 1'b0;
            advance_r     <= 1'b0;
            step_r        <= {1'b0, SPEED_DEFAULT} + 4'd1;
        end else begin
            joy_r         <= bus.joystick_0[BTN_TRAILS:BTN_IN];
            tog_prev_r    <= joy_r[KEY_TRAILS:KEY_PAUSE];
            vblank_r      <= bus.vblank;
            vblank_prev_r <= vblank_r;
            zoom_r        <= zoom_next_s;
            speed_r       <= speed_next_s;
            paused_r      <= paused_next_s;
            trails_r      <= trails_next_s;
            pend_pause_r  <= pend_pause_next_s;
            pend_trails_r <= pend_trails_next_s;
            advance_r     <= tick_next_s & ~paused_next_s;
            step_r        <= {1'b0, speed_next_s} + 4'd1;
        end
    end

    assign bus.zoom    = zoom_r;
    assign bus.speed   = speed_r;
    assign bus.paused  = paused_r;
    assign bus.trails  = trails_r;
    assign bus.advance = advance_r;
    assign bus.step    = step_r;

endmodule

// File: tb/tb_bubble_param_ctrl.sv
// Directed bench for bubble_param_ctrl: frame ticks are produced by pulsing
// vblank, expected parameter values are hand-derived per tick.
module tb_bubble_param_ctrl;

    logic       clk;
    logic       reset_n;
    int         checks = 0;
    int         failures = 0;
    int         adv_cnt = 0;
    logic [3:0] last_step = 4'd0;
    int         base;

    bubble_param_ctrl_if bus ();

    bubble_param_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count advance pulses and remember the step that came with the last one
    always @(negedge clk) begin
        if (bus.advance === 1'b1) begin
            adv_cnt   <= adv_cnt + 1;
            last_step <= bus.step;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame: vblank high 3 cycles, low 3 cycles; starts/ends on negedge
    task automatic frame();
        bus.vblank = 1'b1;
        repeat (3) @(negedge clk);
        bus.vblank = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    // Number of repeat actions after k ticks of holding one key
    function automatic int n_act(input int k);
        if (k < 1) return 0;
        else if (k < 25) return 1;
        else return 2 + (k - 25) / 6;
    endfunction

    initial begin
        reset_n        = 1'b0;
        bus.joystick_0 = 32'd0;
        bus.vblank     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_zoom", int'(bus.zoom), 8);
        chk("rst_speed", int'(bus.speed), 3);
        chk("rst_paused", int'(bus.paused), 0);
        chk("rst_trails", int'(bus.trails), 0);
        chk("rst_advance", int'(bus.advance), 0);
        chk("rst_step", int'(bus.step), 4);
        reset_n = 1'b1;
        settle();

        // Three idle frames; bits outside 4..9 must be ignored
        bus.joystick_0 = 32'hFFFF_FC0F;
        settle();
        for (int k = 0; k < 3; k++) frame();
        chk("idle_adv_cnt", adv_cnt, 3);
        chk("idle_step", int'(last_step), 4);
        chk("idle_zoom", int'(bus.zoom), 8);
        chk("idle_speed", int'(bus.speed), 3);
        bus.joystick_0 = 32'd0;
        settle();

        // In held 40 ticks: 9@1, 10@25, 11@31, 12@37
        bus.joystick_0 = 32'h0000_0010;
        settle();
        for (int k = 1; k <= 40; k++) begin
            frame();
            chk("in_hold_zoom", int'(bus.zoom), 8 + n_act(k));
        end
        bus.joystick_0 = 32'd0;
        settle();
        for (int k = 0; k < 3; k++) frame();
        chk("in_release_zoom", int'(bus.zoom), 12);

        // Faster held 60 ticks: saturates at 7
        bus.joystick_0 = 32'h0000_0040;
        settle();
        for (int k = 1; k <= 60; k++) begin
            frame();
            chk("faster_speed", int'(bus.speed), (3 + n_act(k) > 7) ? 7 : 3 + n_act(k));
        end
        chk("faster_step", int'(last_step), 8);

        // Slower held 60 ticks: saturates at 0
        bus.joystick_0 = 32'h0000_0080;
        settle();
        for (int k = 1; k <= 60; k++) begin
            frame();
            chk("slower_speed", int'(bus.speed), (7 - n_act(k) < 0) ? 0 : 7 - n_act(k));
        end
        chk("slower_step", int'(last_step), 1);
        bus.joystick_0 = 32'd0;
        settle();

        // Pause pressed twice between ticks: a single toggle
        base = adv_cnt;
        for (int p = 0; p < 2; p++) begin
            bus.joystick_0 = 32'h0000_0100;
            settle();
            bus.joystick_0 = 32'd0;
            settle();
        end
        frame();
        chk("pause_on", int'(bus.paused), 1);
        chk("pause_tick_adv", adv_cnt, base + 1);
        frame();
        frame();
        chk("paused_no_adv", adv_cnt, base + 1);
        chk("pause_held", int'(bus.paused), 1);
        bus.joystick_0 = 32'h0000_0100;
        settle();
        bus.joystick_0 = 32'd0;
        settle();
        frame();
        chk("pause_off", int'(bus.paused), 0);
        chk("unpause_tick_adv", adv_cnt, base + 1);
        frame();
        chk("resume_adv", adv_cnt, base + 2);
        chk("resume_step", int'(last_step), 1);

        // Trails toggle
        bus.joystick_0 = 32'h0000_0200;
        settle();
        bus.joystick_0 = 32'd0;
        settle();
        frame();
        chk("trails_on", int'(bus.trails), 1);

        // In+Out together: In wins; drop In -> Out restarts
        bus.joystick_0 = 32'h0000_0030;
        settle();
        frame();
        chk("in_out_zoom", int'(bus.zoom), 13);
        bus.joystick_0 = 32'h0000_0020;
        settle();
        frame();
        chk("out_restart_zoom", int'(bus.zoom), 12);
        bus.joystick_0 = 32'd0;
        settle();

        // Reset during REPEAT with In still held
        bus.joystick_0 = 32'h0000_0010;
        settle();
        for (int k = 1; k <= 26; k++) frame();
        chk("pre_reset_zoom", int'(bus.zoom), 14);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_zoom", int'(bus.zoom), 8);
        chk("mid_rst_speed", int'(bus.speed), 3);
        chk("mid_rst_paused", int'(bus.paused), 0);
        chk("mid_rst_trails", int'(bus.trails), 0);
        chk("mid_rst_advance", int'(bus.advance), 0);
        chk("mid_rst_step", int'(bus.step), 4);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_no_action", int'(bus.zoom), 8);
        frame();
        chk("post_rst_first_zoom", int'(bus.zoom), 9);
        chk("post_rst_step", int'(last_step), 4);
        bus.joystick_0 = 32'd0;
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
